// File: rtl/fifo_uart_tx_if.sv
// Read-side port of the show-ahead byte FIFO.
// master is the consumer that issues pops; slave is the FIFO.
interface fifo_uart_tx_if;
  logic [7:0] fifo_data;
  logic       empty;
  logic       rdreq;

  modport master (input fifo_data, input empty, output rdreq);
  modport slave  (output fifo_data, output empty, input rdreq);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead byte FIFO, LSB first, with optional
// parity and 1 or 2 stop bits; frames run back-to-back while data remains.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             PAR_EN    = (PARITY != 0);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_d, busy_d, done_d;
  logic             cnt_end, last_stop;

  assign cnt_end   = (cnt_q == CNT_LAST);
  assign last_stop = (state_q == STOP) && (stop_q == STOP_LAST) && cnt_end;

  // Pop only from IDLE or on the final stop cycle, so frames chain with no gap.
  assign fifo.rdreq = !rst && enable && !fifo.empty && (state_q == IDLE || last_stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (state_q != IDLE) cnt_d = cnt_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      START: begin
        if (cnt_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (cnt_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          par_d   = par_q ^ shift_q[0];
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = PAR_EN ? PAR : STOP;
            stop_d  = 1'b0;
          end
        end
      end
      PAR: begin
        if (cnt_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (cnt_end) begin
          if (stop_q == STOP_LAST) state_d = IDLE;
          else                     stop_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if (fifo.rdreq) begin
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      stop_d  = 1'b0;
      shift_d = fifo.fifo_data;
      par_d   = 1'b0;
    end

    // Registered outputs are derived from the next state so tx changes on the pop edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d ^ PAR_ODD;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (stop_d == STOP_LAST) && (cnt_d == CNT_LAST);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameterisations fed from byte-queue FIFO models,
// checked per cycle against a frame-level reference plus directed vectors.
module tb_fifo_uart_tx;

  localparam int CLK  = 4;
  localparam int NDUT = 3;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [11:0] bits;   // expected line levels in order, first level at [11]
    int          nbits;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;

  logic [NDUT-1:0] tx_v, busy_v, done_v, rdreq_v, empty_v;
  logic [7:0]      fmem [NDUT][64];
  logic [5:0]      hd [NDUT] = '{default: 6'd0};
  logic [5:0]      tl [NDUT] = '{default: 6'd0};

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  bit          m_act  [NDUT] = '{default: 1'b0};
  int          m_pos  [NDUT] = '{default: 0};
  int          m_cyc  [NDUT] = '{default: 0};
  logic [11:0] m_bits [NDUT] = '{default: 12'hfff};

  vec_t vecs [7];

  fifo_uart_tx_if if0 ();
  fifo_uart_tx_if if1 ();
  fifo_uart_tx_if if2 ();

  for (genvar g = 0; g < NDUT; g++) begin : g_empty
    assign empty_v[g] = (hd[g] == tl[g]);
  end

  assign if0.fifo_data = fmem[0][hd[0]];
  assign if1.fifo_data = fmem[1][hd[1]];
  assign if2.fifo_data = fmem[2][hd[2]];
  assign if0.empty = empty_v[0];
  assign if1.empty = empty_v[1];
  assign if2.empty = empty_v[2];
  assign rdreq_v = {if2.rdreq, if1.rdreq, if0.rdreq};

  fifo_uart_tx #(.CLKS_PER_BIT(CLK), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo(if0),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(CLK), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo(if1),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(CLK), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .fifo(if2),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  always #5 clk = ~clk;

  // FIFO model: a pop advances the head on the edge where rdreq is high.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++)
      if (rdreq_v[i]) hd[i] <= hd[i] + 6'd1;
  end

  function automatic int par_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction

  function automatic int nbits_of(input int i);
    return 10 + ((par_of(i) != 0) ? 1 : 0) + ((i == 1) ? 1 : 0);
  endfunction

  // Line levels of one frame: start 0, data LSB first, parity, then 1s.
  function automatic logic [11:0] frame_of(input logic [7:0] b, input int par);
    logic [11:0] f;
    int ones;
    f    = '1;
    ones = $countones(b);
    f[11] = 1'b0;
    for (int j = 0; j < 8; j++) f[10 - j] = b[j];
    if (par == 2)      f[2] = (ones % 2) == 1;
    else if (par == 1) f[2] = (ones % 2) == 0;
    return f;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    fmem[d][tl[d]] = b;
    tl[d] = tl[d] + 6'd1;
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      ok = (&empty_v) && (busy_v == '0);
    end
    check("idle_wait", 0, 32'(ok), 32'd1);
  endtask

  task automatic wait_rdreq(input int d, input int lim, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk);
      seen = rdreq_v[d];
    end
  endtask

  // Reference model: a frame is a list of levels each held CLK cycles.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        logic etx, erd, last;
        last = m_act[i] && (m_pos[i] == m_cyc[i] - 1);
        etx  = m_act[i] ? m_bits[i][4'(11 - m_pos[i] / CLK)] : 1'b1;
        erd  = !rst && enable && !empty_v[i] && (!m_act[i] || last);
        if (mon_on) begin
          check("mon_tx",    i, 32'(tx_v[i]),    32'(etx));
          check("mon_busy",  i, 32'(busy_v[i]),  32'(m_act[i]));
          check("mon_done",  i, 32'(done_v[i]),  32'(last));
          check("mon_rdreq", i, 32'(rdreq_v[i]), 32'(erd));
        end
        if (rst) begin
          m_act[i] = 1'b0;
        end else if (rdreq_v[i]) begin
          m_act[i]  = 1'b1;
          m_pos[i]  = 0;
          m_cyc[i]  = nbits_of(i) * CLK;
          m_bits[i] = frame_of(fmem[i][hd[i]], par_of(i));
        end else if (m_act[i]) begin
          m_pos[i]++;
          if (m_pos[i] == m_cyc[i]) m_act[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    bit seen;
    int d, pulses, dones, busy_low, second_at;

    vecs[0] = '{dut: 0, data: 8'h55, bits: 12'b010101010111, nbits: 10};
    vecs[1] = '{dut: 1, data: 8'hA3, bits: 12'b011000101011, nbits: 12};
    vecs[2] = '{dut: 1, data: 8'h0F, bits: 12'b011110000011, nbits: 12};
    vecs[3] = '{dut: 2, data: 8'h00, bits: 12'b000000000111, nbits: 11};
    vecs[4] = '{dut: 2, data: 8'h01, bits: 12'b010000000011, nbits: 11};
    vecs[5] = '{dut: 0, data: 8'hFF, bits: 12'b011111111111, nbits: 10};
    vecs[6] = '{dut: 0, data: 8'h80, bits: 12'b000000001111, nbits: 10};

    fork
      monitor();
    join_none

    // Reset with everything empty, then 100 quiet cycles.
    repeat (2) @(posedge clk);
    #1 mon_on = 1'b1;
    @(negedge clk);
    check("rst_tx", 0, 32'(tx_v[0]), 32'd1);
    check("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    check("rst_done", 0, 32'(done_v[0]), 32'd0);
    check("rst_rdreq", 0, 32'(rdreq_v[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("quiet_rdreq", 0, 32'(rdreq_v[0]), 32'd0);
      check("quiet_tx", 0, 32'(tx_v[0]), 32'd1);
    end

    // Single-frame vectors.
    for (int r = 0; r < 7; r++) begin
      d = vecs[r].dut;
      wait_idle(200);
      @(posedge clk);
      #1 push(d, vecs[r].data);
      wait_rdreq(d, 5, seen);
      check("vec_rdreq", d, 32'(seen), 32'd1);
      @(posedge clk);
      for (int b = 0; b < vecs[r].nbits; b++)
        for (int c = 0; c < CLK; c++) begin
          @(negedge clk);
          check("vec_tx", d, 32'(tx_v[d]), 32'(vecs[r].bits[4'(11 - b)]));
        end
      check("vec_done", d, 32'(done_v[d]), 32'd1);
      @(negedge clk);
      check("vec_idle", d, 32'(busy_v[d]), 32'd0);
    end

    // Back-to-back frames with parity and two stop bits.
    wait_idle(200);
    @(posedge clk);
    #1;
    push(1, 8'hA3);
    push(1, 8'h0F);
    wait_rdreq(1, 5, seen);
    check("b2b_first", 1, 32'(seen), 32'd1);
    @(posedge clk);
    pulses = 0; dones = 0; busy_low = 0; second_at = -1;
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      if (rdreq_v[1]) begin pulses++; second_at = c; end
      if (done_v[1]) dones++;
      if (!busy_v[1]) busy_low++;
    end
    check("b2b_pulses", 1, 32'(pulses), 32'd1);
    check("b2b_second_at", 1, 32'(second_at), 32'd48);
    check("b2b_dones", 1, 32'(dones), 32'd2);
    check("b2b_busy_gap", 1, 32'(busy_low), 32'd0);
    @(negedge clk);
    check("b2b_idle", 1, 32'(busy_v[1]), 32'd0);

    // Drop enable mid-frame with three bytes queued.
    wait_idle(200);
    @(posedge clk);
    #1;
    push(0, 8'h3C);
    push(0, 8'hE1);
    push(0, 8'h7E);
    wait_rdreq(0, 5, seen);
    check("en_first", 0, 32'(seen), 32'd1);
    repeat (15) @(posedge clk);
    #1 enable = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (rdreq_v[0]) pulses++;
    end
    check("en_pulses", 0, 32'(pulses), 32'd0);
    check("en_busy", 0, 32'(busy_v[0]), 32'd0);
    check("en_left", 0, 32'(6'(tl[0] - hd[0])), 32'd2);
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    check("en_resume", 0, 32'(rdreq_v[0]), 32'd1);
    wait_idle(400);

    // One-cycle reset during data bit 3 (the fifth line bit).
    @(posedge clk);
    #1;
    push(0, 8'h5A);
    push(0, 8'hC3);
    wait_rdreq(0, 5, seen);
    check("mr_first", 0, 32'(seen), 32'd1);
    repeat (18) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mr_tx", 0, 32'(tx_v[0]), 32'd1);
    check("mr_busy", 0, 32'(busy_v[0]), 32'd0);
    check("mr_rdreq", 0, 32'(rdreq_v[0]), 32'd1);
    check("mr_head", 0, 32'(fmem[0][hd[0]]), 32'h0C3);
    wait_idle(200);
    check("mr_drained", 0, 32'(6'(tl[0] - hd[0])), 32'd0);

    // Random traffic, enable toggling and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      d = int'($urandom_range(0, NDUT - 1));
      if ($urandom_range(0, 19) == 0 && 6'(tl[d] - hd[d]) < 6'd60)
        push(d, 8'($urandom));
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      rst = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = 1'b1;
    wait_idle(3000);
    for (int i = 0; i < NDUT; i++)
      check("rand_drained", i, 32'(6'(tl[i] - hd[i])), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains bytes from the single-clock show-ahead byte FIFO and serialises them onto a UART line, LSB first, with an optional parity bit and 1 or 2 stop bits. It is the read-side consumer of that FIFO: it pops only when the FIFO is non-empty and streams frames back-to-back while data remains. It sits between the transmit FIFO and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be at least 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits starting new frames. A frame already in progress always completes.
- `fifo_data`  in  8  FIFO head byte, valid combinationally whenever `empty`=0.
- `empty`  in  1  FIFO empty flag.
- `rdreq`  out  1  FIFO pop, one cycle per byte.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line (START through STOP).
- `done`  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.

## Operation
- States: IDLE, START, DATA, PAR, STOP. There is a bit-cycle counter (width clog2(CLKS_PER_BIT)), a 3-bit data index, a stop index, an 8-bit shift register and a parity accumulator.
- `rdreq` is combinational: `rdreq` = !rst && enable && !empty && (state==IDLE || last cycle of the final stop bit).
  - On any edge where `rdreq`=1: `fifo_data` is latched into the shift register, the counter is cleared, parity is initialised, and the state becomes START.
- Hard rule: `rdreq` is never 1 while `empty`=1, including in the reset cycle.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA: `tx`=shift[0]. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right, XOR the bit into parity, and increment the index. After bit 7, go to PAR if PARITY≠0, else to STOP.
- PAR: `tx` = ^data for even parity, or ~^data for odd parity, for one bit time. Then go to STOP.
- STOP: `tx`=1 for STOP_BITS bit times.
  - On the last cycle, `done`=1.
  - If the `rdreq` condition holds on that cycle, go straight to START (zero idle gap); otherwise go to IDLE.
- `busy`=1 in every state except IDLE.
- `enable` is sampled only at pop decisions. Dropping it mid-frame does not truncate the frame.
- Counter arithmetic is unsigned. The counter wraps to 0 at CLKS_PER_BIT-1, and no counter ever exceeds its declared width.

## Timing
- Reset values: state IDLE, `tx`=1, `busy`=0, `done`=0, `rdreq`=0. Counters are 0.
- Reset mid-frame: on the next edge `tx`=1 and `busy`=0. The popped byte is discarded and is not re-popped.
- `tx`, `busy` and `done` are registered. `rdreq` is combinational from state and inputs.
- Latency: if `rdreq`=1 at edge N, `tx` falls on the cycle after edge N.
- Frame length is (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles exactly.
- Back-to-back frames: the next start bit immediately follows the last stop cycle, with no extra idle cycle.
- From IDLE, the first frame starts one cycle after `empty` falls (with `enable`=1).
- Simultaneous FIFO write and pop is handled by the FIFO. This block only observes `empty`.

## Test plan
- Reset with CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, `empty`=1, `enable`=1 → `tx`=1, `busy`=0, `rdreq` stays 0 for 100 cycles.
- Push 0x55 → one-cycle `rdreq`, then `tx` reads 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles (40 cycles total), `done` pulses on cycle 40, then `busy`=0.
- Push 0xA3 then 0x0F, PARITY=2, STOP_BITS=2 → frames are 0,1,1,0,0,0,1,0,1,0(par),1,1 and 0,1,1,1,1,0,0,0,0,0(par),1,1. They run contiguously, 48 cycles each, with exactly 2 `rdreq` pulses.
- PARITY=1, byte 0x00 → parity bit = 1; byte 0x01 → parity bit = 0.
- Drop `enable` during the data bits of a frame with 3 bytes queued → the current frame completes, then there are no further `rdreq` pulses. Re-raising `enable` resumes with the next byte.
- Assert `rst` for 1 cycle during bit 4 of a frame → `tx`=1 next cycle and `busy`=0. The next FIFO byte is transmitted intact after reset releases, and the aborted byte is not resent.
